nonrestoring_divider_seq: RTL and testbench

Multi-cycle 32-bit radix-2 non-restoring integer divider. It is the divide-side counterpart of the pipelined Booth/Wallace multiplier in the RISC-V processing element. It produces the quotient and remainder for RV32M DIV/DIVU/REM/REMU, including the ISA-defined divide-by-zero and overflow results. It sits beside the multiplier in the execute stage and uses a start/busy/valid handshake instead of a free-running pipeline.

---
 rtl/nonrestoring_divider_seq_if.sv | 29 ++
 rtl/nonrestoring_divider_seq.sv | 123 ++++++++++++
 tb/tb_nonrestoring_divider_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/nonrestoring_divider_seq_if.sv
// ============================================================================
// Module   : nonrestoring_divider_seq_if
// Brief    : Start/busy/valid handshake bundle for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nonrestoring_divider_seq_if;
    logic        start;
    logic        is_signed;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Q;
    logic [31:0] R;
    logic        busy;
    logic        valid;

    modport master (
        output start, is_signed, A, B,
        input  Q, R, busy, valid
    );

    modport slave (
        input  start, is_signed, A, B,
        output Q, R, busy, valid
    );
endinterface

`default_nettype wire

// File: rtl/nonrestoring_divider_seq.sv
// ============================================================================
// Module   : nonrestoring_divider_seq
// Brief    : 32-bit radix-2 non-restoring divider, RV32M DIV/DIVU/REM/REMU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonrestoring_divider_seq (
    input  wire logic                  clk,
    input  wire logic                  rst,
    nonrestoring_divider_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [31:0] r_a_raw;
    logic        r_is_signed;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_div0;
    logic        r_ovf;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_rem_sh;
    logic [32:0] w_rem_nxt;
    logic [31:0] w_rem_fix;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_a_mag = (bus.is_signed && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
    assign w_b_mag = (bus.is_signed && bus.B[31]) ? (32'd0 - bus.B) : bus.B;

    // Decision uses the sign before the shift; the dropped top bit is
    // recovered by the 33-bit modular add/subtract.
    assign w_rem_sh  = {r_rem[31:0], r_quo[31]};
    assign w_rem_nxt = r_rem[32] ? (w_rem_sh + {1'b0, r_div})
                                 : (w_rem_sh - {1'b0, r_div});

    assign w_rem_fix = r_rem[32] ? (r_rem[31:0] + r_div) : r_rem[31:0];
    assign w_q_fix   = (r_is_signed && r_sign_q) ? (32'd0 - r_quo)     : r_quo;
    assign w_r_fix   = (r_is_signed && r_sign_r) ? (32'd0 - w_rem_fix) : w_rem_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 6'd0;
            r_rem       <= 33'd0;
            r_quo       <= 32'd0;
            r_div       <= 32'd0;
            r_a_raw     <= 32'd0;
            r_is_signed <= 1'b0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_div0      <= 1'b0;
            r_ovf       <= 1'b0;
            bus.Q       <= 32'd0;
            bus.R       <= 32'd0;
            bus.busy    <= 1'b0;
            bus.valid   <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_is_signed <= bus.is_signed;
                        r_a_raw     <= bus.A;
                        r_quo       <= w_a_mag;
                        r_div       <= w_b_mag;
                        r_rem       <= 33'd0;
                        r_sign_q    <= bus.is_signed & (bus.A[31] ^ bus.B[31]);
                        r_sign_r    <= bus.is_signed & bus.A[31];
                        r_div0      <= (bus.B == 32'd0);
                        r_ovf       <= bus.is_signed && (bus.A == 32'h8000_0000)
                                                     && (bus.B == 32'hFFFF_FFFF);
                        r_cnt       <= 6'd0;
                        bus.busy    <= 1'b1;
                        r_state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[30:0], ~w_rem_nxt[32]};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_div0) begin
                        bus.Q <= 32'hFFFF_FFFF;
                        bus.R <= r_a_raw;
                    end else if (r_ovf) begin
                        bus.Q <= 32'h8000_0000;
                        bus.R <= 32'd0;
                    end else begin
                        bus.Q <= w_q_fix;
                        bus.R <= w_r_fix;
                    end
                    bus.valid <= 1'b1;
                    bus.busy  <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nonrestoring_divider_seq.sv
// ============================================================================
// Module   : tb_nonrestoring_divider_seq
// Brief    : Scoreboard bench for the sequential non-restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nonrestoring_divider_seq;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    logic clk;
    logic rst;
    nonrestoring_divider_seq_if bus ();

    nonrestoring_divider_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    res_t sb[$];
    int   n_checks;
    int   n_pass;

    function automatic res_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        res_t res;
        if (b == 32'd0) begin
            res.q = 32'hFFFF_FFFF;
            res.r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res.q = 32'h8000_0000;
            res.r = 32'd0;
        end else if (s) begin
            res.q = $unsigned($signed(a) / $signed(b));
            res.r = $unsigned($signed(a) % $signed(b));
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    // Drives one start pulse; returns #1 after the accepting edge.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.A         = a;
        bus.B         = b;
        if (push) sb.push_back(model(s, a, b));
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Counts cycles until valid; busy_ok records busy high before and low at valid.
    task automatic wait_valid(output int cyc, output bit busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        while (bus.valid !== 1'b1 && cyc < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.Q, bus.R, bus.busy, bus.valid} !== 66'd0)
            $display("FAIL reset_state: Q=%h R=%h busy=%b valid=%b, required all zero",
                     bus.Q, bus.R, bus.busy, bus.valid);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [64:0] vec [0:9];
        int   cyc;
        bit   bok;
        res_t exp;
        vec[0] = {1'b1, 32'd100,          32'd7};
        vec[1] = {1'b1, 32'hFFFF_FF9C,    32'd7};
        vec[2] = {1'b1, 32'd100,          32'hFFFF_FFF9};
        vec[3] = {1'b0, 32'hFFFF_FFFF,    32'd2};
        vec[4] = {1'b1, 32'hFFFF_FFFF,    32'd2};
        vec[5] = {1'b1, 32'd1234,         32'd0};
        vec[6] = {1'b0, 32'd1234,         32'd0};
        vec[7] = {1'b1, 32'h8000_0000,    32'hFFFF_FFFF};
        vec[8] = {1'b0, 32'h8000_0000,    32'hFFFF_FFFF};
        vec[9] = {1'b1, 32'hDEAD_BEEF,    32'h0000_1235};
        for (int i = 0; i < 10; i++) begin
            start_op(vec[i][64], vec[i][63:32], vec[i][31:0], 1'b1);
            wait_valid(cyc, bok);
            n_checks++;
            if (cyc != 33 || !bok)
                $display("FAIL latency[%0d]: cycles=%0d busy_ok=%0b, required 33 and 1", i, cyc, bok);
            else n_pass++;
            exp = sb.pop_front();
            n_checks++;
            if (bus.Q !== exp.q || bus.R !== exp.r)
                $display("FAIL result[%0d]: Q=%h R=%h, required Q=%h R=%h", i, bus.Q, bus.R, exp.q, exp.r);
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if (bus.valid !== 1'b0 || bus.Q !== exp.q || bus.R !== exp.r)
                $display("FAIL hold[%0d]: valid=%b Q=%h R=%h, required 0 %h %h",
                         i, bus.valid, bus.Q, bus.R, exp.q, exp.r);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        int   total;
        bit   bok;
        res_t exp;
        start_op(1'b1, 32'd100, 32'd7, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        start_op(1'b1, 32'd9, 32'd3, 1'b0);
        wait_valid(cyc, bok);
        total = cyc + 10;
        exp = sb.pop_front();
        n_checks++;
        if (total != 33 || bus.Q !== exp.q || bus.R !== exp.r)
            $display("FAIL ignore_busy: cycles=%0d Q=%h R=%h, required 33 %h %h",
                     total, bus.Q, bus.R, exp.q, exp.r);
        else n_pass++;
        start_op(1'b1, 32'd9, 32'd3, 1'b1);
        wait_valid(cyc, bok);
        exp = sb.pop_front();
        n_checks++;
        if (cyc != 33 || !bok || bus.Q !== exp.q || bus.R !== exp.r)
            $display("FAIL valid_cycle_start: cycles=%0d Q=%h R=%h, required 33 %h %h",
                     cyc, bus.Q, bus.R, exp.q, exp.r);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int   cyc;
        int   seen;
        bit   bok;
        res_t exp;
        start_op(1'b1, 32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.Q !== 32'd0 || bus.R !== 32'd0 || bus.busy !== 1'b0 || bus.valid !== 1'b0)
            $display("FAIL reset_abort: Q=%h R=%h busy=%b valid=%b, required all zero",
                     bus.Q, bus.R, bus.busy, bus.valid);
        else n_pass++;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1 || bus.busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0)
            $display("FAIL no_valid_after_abort: activity cycles=%0d, required 0", seen);
        else n_pass++;
        start_op(1'b0, 32'd50, 32'd5, 1'b1);
        wait_valid(cyc, bok);
        exp = sb.pop_front();
        n_checks++;
        if (cyc != 33 || !bok || bus.Q !== exp.q || bus.R !== exp.r)
            $display("FAIL after_reset: cycles=%0d Q=%h R=%h, required 33 %h %h",
                     cyc, bus.Q, bus.R, exp.q, exp.r);
        else n_pass++;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.A         = 32'd0;
        bus.B         = 32'd0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
